// File: rtl/player_missile_pool.sv
// Purpose: pool of N_MISSILES player missiles with fire-key detect, slot allocation, cooldown, upward motion and retirement.
// Latency: fire request to exist/fire_pulse is one frame_clk cycle; position updates appear one cycle after the registered Y they use.
// Backpressure: none; a fire request with no free slot or a running cooldown is dropped. Define PLAYER_MISSILE_AUTOFIRE_EN for a level-sensitive fire key.
module player_missile_pool #(
  parameter int         N_MISSILES = 4,
  parameter logic [7:0] FIRE_KEY   = 8'd44,
  parameter logic [9:0] Y_START    = 10'd448,
  parameter logic [9:0] Y_MIN      = 10'd0,
  parameter logic [9:0] Y_STEP     = 10'd4,
  parameter logic [9:0] X_OFFSET   = 10'd8,
  parameter logic [5:0] COOLDOWN   = 6'd10
) (
  input  logic                      frame_clk,
  input  logic                      Reset,
  input  logic [7:0]                keycode,
  input  logic [9:0]                ship_x,
  input  logic [N_MISSILES-1:0]     collided,
  output logic [10*N_MISSILES-1:0]  pmX,
  output logic [10*N_MISSILES-1:0]  pmY,
  output logic [N_MISSILES-1:0]     exist,
  output logic                      ready,
  output logic                      fire_pulse,
  output logic [3:0]                active_count
);

  // A missile at or above this row retires instead of moving past the top edge.
  localparam logic [9:0] RETIRE_Y = Y_MIN + Y_STEP;

  logic [9:0]            x_q [N_MISSILES];
  logic [9:0]            x_d [N_MISSILES];
  logic [9:0]            y_q [N_MISSILES];
  logic [9:0]            y_d [N_MISSILES];
  logic [N_MISSILES-1:0] exist_q, exist_d;
  logic [5:0]            cooldown_q, cooldown_d;
  logic                  fire_pulse_q, fire_pulse_d;
  logic                  fire_hit, fire_req, spawn, any_free;
  logic [N_MISSILES-1:0] alloc_oh;
  logic                  alloc_found;
`ifndef PLAYER_MISSILE_AUTOFIRE_EN
  logic                  fire_prev_q, fire_prev_d;
`endif

  // Fire request qualification and ready (free slot in the registered exist vector, cooldown expired).
  always_comb begin
    fire_hit = (keycode == FIRE_KEY);
`ifdef PLAYER_MISSILE_AUTOFIRE_EN
    fire_req = fire_hit;
`else
    fire_prev_d = fire_hit;
    fire_req    = fire_hit && !fire_prev_q;
`endif
    any_free = ~&exist_q;
    ready    = any_free && (cooldown_q == 6'd0);
    spawn    = fire_req && ready;
  end

  // Pick the lowest-index free slot as a one-hot vector.
  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < N_MISSILES; i++) begin
      if (!alloc_found && !exist_q[i]) begin
        alloc_oh[i] = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

  // Per-slot motion/retirement for live slots, spawn into the chosen free slot, and cooldown.
  always_comb begin
    exist_d = exist_q;
    for (int i = 0; i < N_MISSILES; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
      if (exist_q[i]) begin
        if (collided[i]) begin
          exist_d[i] = 1'b0;
          y_d[i]     = Y_START;
        end else if (y_q[i] <= RETIRE_Y) begin
          exist_d[i] = 1'b0;
          y_d[i]     = Y_START;
        end else begin
          y_d[i] = y_q[i] - Y_STEP;
        end
      end else if (spawn && alloc_oh[i]) begin
        x_d[i]     = ship_x + X_OFFSET;
        y_d[i]     = Y_START;
        exist_d[i] = 1'b1;
      end
    end
    if (spawn) begin
      cooldown_d = COOLDOWN;
    end else if (cooldown_q != 6'd0) begin
      cooldown_d = cooldown_q - 6'd1;
    end else begin
      cooldown_d = 6'd0;
    end
    fire_pulse_d = spawn;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      for (int i = 0; i < N_MISSILES; i++) begin
        x_q[i] <= '0;
        y_q[i] <= Y_START;
      end
      exist_q      <= '0;
      cooldown_q   <= '0;
      fire_pulse_q <= 1'b0;
`ifndef PLAYER_MISSILE_AUTOFIRE_EN
      fire_prev_q  <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < N_MISSILES; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
      exist_q      <= exist_d;
      cooldown_q   <= cooldown_d;
      fire_pulse_q <= fire_pulse_d;
`ifndef PLAYER_MISSILE_AUTOFIRE_EN
      fire_prev_q  <= fire_prev_d;
`endif
    end
  end

  // Pack slot positions onto the output buses and count live slots.
  always_comb begin
    pmX          = '0;
    pmY          = '0;
    active_count = '0;
    for (int i = 0; i < N_MISSILES; i++) begin
      pmX[10*i +: 10] = x_q[i];
      pmY[10*i +: 10] = y_q[i];
      active_count    = active_count + {3'b000, exist_q[i]};
    end
  end

  assign exist      = exist_q;
  assign fire_pulse = fire_pulse_q;

endmodule

// File: tb/tb_player_missile_pool.sv
`timescale 1ns/1ps
module tb_player_missile_pool;
  localparam int N = 4;

  logic          frame_clk = 1'b0;
  logic          Reset;
  logic [7:0]    keycode;
  logic [9:0]    ship_x;
  logic [N-1:0]  collided;
  logic [10*N-1:0] pmX, pmY;
  logic [N-1:0]  exist;
  logic          ready, fire_pulse;
  logic [3:0]    active_count;

  always #5 frame_clk = ~frame_clk;

  player_missile_pool dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .keycode      (keycode),
    .ship_x       (ship_x),
    .collided     (collided),
    .pmX          (pmX),
    .pmY          (pmY),
    .exist        (exist),
    .ready        (ready),
    .fire_pulse   (fire_pulse),
    .active_count (active_count)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: plain integer positions per slot.
  int m_x [N];
  int m_y [N];
  bit m_ex [N];
  int m_cool;
  bit m_prev, m_pulse;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst_n, input int key, input int sx, input bit [N-1:0] col);
    bit req, spawn;
    int slot;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_x[i] = 0; m_y[i] = 448; m_ex[i] = 0;
      end
      m_cool = 0; m_prev = 0; m_pulse = 0;
    end else begin
`ifdef PLAYER_MISSILE_AUTOFIRE_EN
      req = (key == 44);
`else
      req = (key == 44) && !m_prev;
`endif
      slot = -1;
      for (int i = 0; i < N; i++) if (!m_ex[i] && slot < 0) slot = i;
      spawn = req && (slot >= 0) && (m_cool == 0);
      for (int i = 0; i < N; i++) begin
        if (m_ex[i]) begin
          if (col[i]) begin
            m_ex[i] = 0; m_y[i] = 448;
          end else if (m_y[i] <= 0 + 4) begin
            m_ex[i] = 0; m_y[i] = 448;
          end else begin
            m_y[i] = m_y[i] - 4;
          end
        end else if (spawn && i == slot) begin
          m_x[i] = (sx + 8) % 1024; m_y[i] = 448; m_ex[i] = 1;
        end
      end
      m_cool  = spawn ? 10 : ((m_cool > 0) ? m_cool - 1 : 0);
      m_pulse = spawn;
      m_prev  = (key == 44);
    end
  endtask

  task automatic compare_all();
    logic [10*N-1:0] ex_x, ex_y;
    logic [N-1:0] ex_e;
    int cnt;
    bit any_free;
    cnt = 0; any_free = 0;
    for (int i = 0; i < N; i++) begin
      ex_x[10*i +: 10] = 10'(m_x[i]);
      ex_y[10*i +: 10] = 10'(m_y[i]);
      ex_e[i] = m_ex[i];
      cnt += m_ex[i];
      if (!m_ex[i]) any_free = 1;
    end
    chk("pmX", pmX, ex_x);
    chk("pmY", pmY, ex_y);
    chk("exist", exist, ex_e);
    chk("ready", ready, any_free && (m_cool == 0));
    chk("fire_pulse", fire_pulse, m_pulse);
    chk("active_count", active_count, cnt);
  endtask

  task automatic cycle();
    @(posedge frame_clk);
    model_step(Reset, keycode, ship_x, collided);
    #1;
    compare_all();
  endtask

  initial begin
    int n, shots, maxc, den;
    Reset = 1'b0; keycode = 8'd0; ship_x = 10'd0; collided = '0;
    cycle(); cycle();
    Reset = 1'b1;

    // Reset while a slot is in flight.
    keycode = 8'd44; ship_x = 10'd100; cycle();
    keycode = 8'd0; cycle(); cycle();
    chk("inflight_exist", exist, 4'b0001);
    Reset = 1'b0; cycle(); cycle();
    chk("rst_exist", exist, 4'b0000);
    chk("rst_pmY", pmY, {4{10'd448}});
    chk("rst_pmX", pmX, 40'd0);
    chk("rst_ready", ready, 1);
    chk("rst_count", active_count, 0);
    Reset = 1'b1;

    // Single shot, then let it fly to the top edge.
    keycode = 8'd44; ship_x = 10'd100; cycle();
    chk("shot_exist", exist, 4'b0001);
    chk("shot_x", pmX[9:0], 108);
    chk("shot_y", pmY[9:0], 448);
    chk("shot_pulse", fire_pulse, 1);
    keycode = 8'd0; cycle();
    chk("move_y", pmY[9:0], 444);
    chk("move_pulse", fire_pulse, 0);
    n = 1;
    while (exist[0] && n < 200) begin
      cycle(); n++;
    end
    chk("retire_cycles", n, 112);
    chk("retire_y", pmY[9:0], 448);

    // Hold the fire key for 30 cycles.
    Reset = 1'b0; cycle(); Reset = 1'b1;
    keycode = 8'd44; shots = 0; maxc = 0;
    for (int c = 0; c < 30; c++) begin
      cycle();
      shots += fire_pulse;
      if (active_count > maxc) maxc = active_count;
    end
    keycode = 8'd0;
`ifdef PLAYER_MISSILE_AUTOFIRE_EN
    chk("hold_shots", shots, 3);
    chk("hold_maxcount", maxc, 3);
    chk("hold_exist", exist, 4'b0111);
`else
    chk("hold_shots", shots, 1);
    chk("hold_maxcount", maxc, 1);
    chk("hold_exist", exist, 4'b0001);
`endif

    // Fill every slot, then press with the pool full.
    Reset = 1'b0; cycle(); Reset = 1'b1; ship_x = 10'd200;
    for (int s = 0; s < N; s++) begin
      keycode = 8'd44; cycle();
      chk("fill_pulse", fire_pulse, 1);
      keycode = 8'd0; repeat (11) cycle();
    end
    chk("fill_exist", exist, 4'b1111);
    chk("fill_ready", ready, 0);
    keycode = 8'd44; cycle();
    chk("full_pulse", fire_pulse, 0);
    chk("full_exist", exist, 4'b1111);
    keycode = 8'd0; cycle();
    collided = 4'b0100; cycle(); collided = '0;
    chk("hit2_exist", exist, 4'b1011);
    chk("hit2_count", active_count, 3);
    ship_x = 10'd300; keycode = 8'd44; cycle();
    chk("realloc_exist", exist, 4'b1111);
    chk("realloc_x2", pmX[29:20], 308);
    chk("realloc_y2", pmY[29:20], 448);
    keycode = 8'd0; repeat (11) cycle();

    // Collision on the only candidate slot in the same cycle as a fire request.
    keycode = 8'd44; collided = 4'b0010; cycle();
    chk("cf_exist", exist, 4'b1101);
    chk("cf_pulse", fire_pulse, 0);
    collided = '0; keycode = 8'd0; cycle();
    keycode = 8'd44; ship_x = 10'd50; cycle();
    chk("cf2_exist", exist, 4'b1111);
    chk("cf2_x1", pmX[19:10], 58);
    chk("cf2_pulse", fire_pulse, 1);
    keycode = 8'd0; cycle();

    // Randomized traffic: dense collisions first, then sparse so missiles reach the top.
    for (int c = 0; c < 2500; c++) begin
      den = (c < 1250) ? 16 : 400;
      Reset = ($urandom_range(0, 599) != 0);
      keycode = ($urandom_range(0, 2) == 0) ? 8'd44 : 8'($urandom_range(0, 255));
      ship_x = 10'($urandom_range(0, 1023));
      for (int b = 0; b < N; b++) collided[b] = ($urandom_range(0, den - 1) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/player_missile_pool.md
Name: player_missile_pool

Overview:
- Parametrised successor to the single-shot player missile: manages a pool of N_MISSILES independent player missiles.
- Handles fire-key detection, free-slot allocation, fire cooldown, per-frame upward motion, and retirement at the top edge or on collision.
- Sits between the keyboard keycode path and the collision/colour-mapper logic.
- Advances once per frame_clk edge, i.e. once per video frame.

Parameters:
- N_MISSILES, 4: number of missile slots (1..8).
- FIRE_KEY, 8'd44: keycode that requests a shot (space bar).
- Y_START, 10'd448: spawn Y position.
- Y_MIN, 10'd0: top boundary.
- Y_STEP, 10'd4: upward pixels moved per frame.
- X_OFFSET, 10'd8: spawn X offset added to ship_x.
- COOLDOWN, 6'd10: frames after a shot during which no new shot is accepted.

Ports:
- frame_clk  input  1  frame-rate clock; all state updates on its rising edge.
- Reset  input  1  synchronous, active-low reset.
- keycode  input  8  current keyboard keycode.
- ship_x  input  10  current ship X position.
- collided  input  N_MISSILES  per-slot hit flag from collision logic; bit i applies to slot i.
- pmX  output  10*N_MISSILES  packed X positions; slot i is at bits [10*i+9:10*i].
- pmY  output  10*N_MISSILES  packed Y positions, same packing as pmX.
- exist  output  N_MISSILES  slot i is in flight.
- ready  output  1  a free slot exists and the cooldown counter is 0.
- fire_pulse  output  1  high for exactly one cycle when a shot is spawned.
- active_count  output  4  number of set bits in exist.

Behaviour:
- Reset: sampled only on a rising frame_clk edge while Reset==0. After reset:
  - exist=0, all pmX=0, all pmY=Y_START.
  - cooldown=0, fire_pulse=0, fire_prev=0.
  - ready=1 after reset (combinational from exist and cooldown).
- Reset asserted mid-flight clears every slot on that edge; no retire side effects.
- Fire request: fire_req = (keycode==FIRE_KEY) && !fire_prev. fire_prev registers (keycode==FIRE_KEY) every cycle, so the key must be released and pressed again to fire a second shot.
- Allocation: on fire_req while ready==1, the lowest-index slot with exist==0 is loaded:
  - X = ship_x + X_OFFSET, Y = Y_START, exist=1.
  - cooldown loads COOLDOWN; fire_pulse=1 on the following cycle's outputs.
  - Only one slot is loaded per cycle.
- fire_req while ready==0 is dropped; it is not queued.
- Free-slot test uses the registered exist vector. A slot retiring on cycle t is allocatable from cycle t+1, never on cycle t itself.
- Cooldown: decrements by 1 per cycle while nonzero; saturates at 0.
- Per-slot motion, evaluated every cycle for each slot with exist==1, in priority order:
  1. collided[i]==1: exist<=0, Y<=Y_START, X held.
  2. Y <= Y_MIN + Y_STEP: exist<=0, Y<=Y_START (top-edge retire; no wrap-around).
  3. Otherwise: Y <= Y - Y_STEP, X unchanged.
- Slots with exist==0 hold X and Y. collided[i] is ignored when exist[i]==0.
- The motion update uses the current registered Y; the new position appears one cycle later.
- A newly spawned slot first moves on the cycle after spawn.
- Arithmetic: all position math is 10-bit unsigned. ship_x + X_OFFSET overflow truncates to 10 bits.
- Simultaneous events: collision on slot j and fire in the same cycle behave independently. If j is the only candidate slot, the fire is dropped because j is still busy on that cycle.
- active_count: combinational popcount of exist, 0..N_MISSILES.
- Timing: fire-to-exist latency is 1 cycle. A missile from Y_START=448 with Y_STEP=4 retires after floor((448-4)/4)+1 = 112 moves.

Optional Feature:
- Macro PLAYER_MISSILE_AUTOFIRE_EN.
- Defined: fire_req = (keycode==FIRE_KEY), level-sensitive. Holding the key fires every time ready==1, so the shot rate is limited by COOLDOWN and free slots.
- Undefined: edge-triggered behaviour as described above; fire_prev logic is present.

Test Plan:
- Reset low for 2 cycles with a slot in flight, then high -> exist=0, pmY all 448, ready=1, active_count=0.
- keycode 44 for 1 cycle, ship_x=100 -> next cycle exist=4'b0001, pmX[9:0]=108, pmY[9:0]=448, fire_pulse=1. Following cycle pmY[9:0]=444 and fire_pulse=0.
- Hold keycode 44 for 30 cycles:
  - Macro undefined: exactly one shot.
  - Macro defined: shots on cycles 0, 11 and 22 into slots 0, 1, 2 (cooldown 10 each), with active_count reaching 3.
- Fill all 4 slots (release and press the key, cooldown expired each time), then press again -> no spawn, ready=0. Set collided=4'b0100 -> slot 2 clears; next press allocates slot 2, not slot 3.
- Single shot left to fly -> exist[0] falls exactly 112 cycles after spawn and pmY[9:0] returns to 448.
- collided[1]=1 on the same cycle as a fire request with only slot 1 candidate free-pending -> fire dropped, slot 1 cleared. Fire on the next cycle -> slot 1 loaded.
